// File: rtl/regfile_writeback.sv
// regfile_writeback: writeback stage register file.
// Commits the EX/WB latch result into a 32x32 register file, serves two
// decode read ports with optional same-cycle write bypass, and tracks a busy
// scoreboard of destinations that have been issued but not yet written back.
module regfile_writeback #(
  parameter logic BYPASS   = 1'b1,
  parameter logic READ_REG = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] alu,
  input  logic        aluToReg,
  input  logic [4:0]  rd,
  input  logic        issueValid,
  input  logic [4:0]  issueRd,
  input  logic [4:0]  rs1Addr,
  input  logic [4:0]  rs2Addr,
  output logic [31:0] rs1Data,
  output logic [31:0] rs2Data,
  output logic        rs1Busy,
  output logic        rs2Busy
);

  logic [31:0] regs_q [32];
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic        commit;
  logic        issue;

  // x0 is excluded here, so it can never be written or marked busy.
  assign commit = aluToReg && !stall && (rd != 5'd0);
  assign issue  = issueValid && !stall && (issueRd != 5'd0);

  // Scoreboard next state: commit clears, a same-edge issue to the same
  // register wins because it is applied last.
  always_comb begin
    busy_d = busy_q;
    if (commit) begin
      busy_d[rd] = 1'b0;
    end
    if (issue) begin
      busy_d[issueRd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Register array and scoreboard update; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (commit) begin
        regs_q[rd] <= alu;
      end
      busy_q <= busy_d;
    end
  end

  // One read port per generate iteration; port 0 is rs1, port 1 is rs2.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [4:0]  addr;
      logic [31:0] rdata_d;
      logic        rbusy_d;
      logic [31:0] rdata;
      logic        rbusy;

      assign addr = (gi == 0) ? rs1Addr : rs2Addr;

      // Read data with optional bypass of this cycle's commit; busy is
      // masked when this cycle's commit retires the pending write.
      always_comb begin
        rdata_d = regs_q[addr];
        if (addr == 5'd0) begin
          rdata_d = '0;
        end else if (BYPASS && commit && (rd == addr)) begin
          rdata_d = alu;
        end
        rbusy_d = busy_q[addr] &&
                  !(commit && (rd == addr) && !(issue && (issueRd == addr)));
      end

      if (READ_REG) begin : g_reg
        logic [31:0] rdata_q;
        logic        rbusy_q;

        // Registered read port: capture when the pipeline advances, hold under stall.
        always_ff @(posedge clk) begin
          if (reset) begin
            rdata_q <= '0;
            rbusy_q <= 1'b0;
          end else if (!stall) begin
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
          end
        end

        assign rdata = rdata_q;
        assign rbusy = rbusy_q;
      end else begin : g_comb
        assign rdata = rdata_d;
        assign rbusy = rbusy_d;
      end
    end
  endgenerate

  assign rs1Data = g_port[0].rdata;
  assign rs1Busy = g_port[0].rbusy;
  assign rs2Data = g_port[1].rdata;
  assign rs2Busy = g_port[1].rbusy;

endmodule
